// File: rtl/tiny_dnn_buf_dma.sv
// tiny_dnn_buf_dma: host-side streaming engine for the core's buffers.
//  - Load channel: inbound 16-bit valid/ready stream -> sequential source-buffer writes.
//  - Drain channel: sequential destination-buffer reads (1-cycle latency) -> outbound
//    32-bit valid/ready stream with last marking, through a 2-entry output FIFO.
// Optional feature macro: TINY_DNN_DMA_LAST_CHECK_EN (s_last vs. length check -> src_err).
module tiny_dnn_buf_dma #(
  parameter int AW = 12,
  parameter int SW = 16,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          src_start,
  input  logic [AW-1:0] src_base,
  input  logic [AW:0]   src_len,
  output logic          src_busy,
  output logic          src_done,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [SW-1:0] s_data,
  input  logic          s_last,
  output logic          src_v,
  output logic [AW-1:0] src_a,
  output logic [SW-1:0] src_d,
  input  logic          dst_start,
  input  logic [AW-1:0] dst_base,
  input  logic [AW:0]   dst_len,
  output logic          dst_busy,
  output logic          dst_done,
  output logic          dst_v,
  output logic [AW-1:0] dst_a,
  input  logic [DW-1:0] dst_d,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  output logic          src_err
);

  localparam logic [AW-1:0] ONE_A = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   ONE_L = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   ZERO_L = '0;

  typedef enum logic {L_IDLE, L_LOAD} load_state_t;
  typedef enum logic [1:0] {D_IDLE, D_READ, D_FLUSH} drain_state_t;

  // ---------------- load channel ----------------
  load_state_t   ld_state_reg;
  logic [AW-1:0] ld_addr_reg;
  logic [AW:0]   ld_left_reg;

  assign s_ready  = (ld_state_reg == L_LOAD);
  assign src_busy = (ld_state_reg == L_LOAD);

  // Load FSM: every accepted beat becomes a registered buffer write on the next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      ld_state_reg <= L_IDLE;
      ld_addr_reg  <= '0;
      ld_left_reg  <= '0;
      src_v        <= 1'b0;
      src_a        <= '0;
      src_d        <= '0;
      src_done     <= 1'b0;
    end else begin
      src_v    <= 1'b0;
      src_done <= 1'b0;
      case (ld_state_reg)
        L_IDLE: begin
          if (src_start) begin
            ld_addr_reg <= src_base;
            ld_left_reg <= src_len;
            if (src_len == ZERO_L) src_done <= 1'b1;
            else                   ld_state_reg <= L_LOAD;
          end
        end
        L_LOAD: begin
          if (s_valid) begin
            src_v       <= 1'b1;
            src_a       <= ld_addr_reg;
            src_d       <= s_data;
            ld_addr_reg <= ld_addr_reg + ONE_A;
            ld_left_reg <= ld_left_reg - ONE_L;
            // Final beat: done pulse lines up with the final write strobe.
            if (ld_left_reg == ONE_L) begin
              ld_state_reg <= L_IDLE;
              src_done     <= 1'b1;
            end
          end
        end
        default: ld_state_reg <= L_IDLE;
      endcase
    end
  end

`ifdef TINY_DNN_DMA_LAST_CHECK_EN
  logic err_reg;
  assign src_err = err_reg;

  // Sticky flag: s_last must be set on exactly the len-th accepted beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_reg <= 1'b0;
    end else if (ld_state_reg == L_IDLE && src_start) begin
      err_reg <= 1'b0;
    end else if (ld_state_reg == L_LOAD && s_valid && (s_last != (ld_left_reg == ONE_L))) begin
      err_reg <= 1'b1;
    end
  end
`else
  logic unused_s_last;
  assign unused_s_last = s_last;
  assign src_err = 1'b0;
`endif

  // ---------------- drain channel ----------------
  drain_state_t  dr_state_reg;
  logic [AW-1:0] rd_addr_reg;
  logic [AW:0]   rd_left_reg;
  logic          pend_reg;
  logic          pend_last_reg;
  logic [DW:0]   fifo_mem [2];
  logic          wr_ptr_reg;
  logic          rd_ptr_reg;
  logic [1:0]    cnt_reg;
  logic [DW:0]   head;
  logic          pop;
  logic [2:0]    occ;
  logic          issue;

  assign head  = fifo_mem[rd_ptr_reg];
  assign pop   = (cnt_reg != 2'd0) && m_ready;
  // Slots committed after this cycle: buffered + in flight - leaving now.
  assign occ   = {1'b0, cnt_reg} + {2'b00, pend_reg} - {2'b00, pop};
  assign issue = !reset && (dr_state_reg == D_READ) && (rd_left_reg != ZERO_L) && (occ < 3'd2);

  assign dst_v    = issue;
  assign dst_a    = rd_addr_reg;
  assign dst_busy = (dr_state_reg != D_IDLE);
  assign m_valid  = (cnt_reg != 2'd0);
  assign m_data   = m_valid ? head[DW-1:0] : '0;
  assign m_last   = m_valid & head[DW];

  // Drain FSM: issue reads while credit allows, then wait for the last beat to leave.
  always_ff @(posedge clk) begin
    if (reset) begin
      dr_state_reg <= D_IDLE;
      rd_addr_reg  <= '0;
      rd_left_reg  <= '0;
      dst_done     <= 1'b0;
    end else begin
      dst_done <= 1'b0;
      case (dr_state_reg)
        D_IDLE: begin
          if (dst_start) begin
            rd_addr_reg <= dst_base;
            rd_left_reg <= dst_len;
            if (dst_len == ZERO_L) dst_done <= 1'b1;
            else                   dr_state_reg <= D_READ;
          end
        end
        D_READ: begin
          if (issue) begin
            rd_addr_reg <= rd_addr_reg + ONE_A;
            rd_left_reg <= rd_left_reg - ONE_L;
            if (rd_left_reg == ONE_L) dr_state_reg <= D_FLUSH;
          end
        end
        D_FLUSH: begin
          if (pop && head[DW]) begin
            dr_state_reg <= D_IDLE;
            dst_done     <= 1'b1;
          end
        end
        default: dr_state_reg <= D_IDLE;
      endcase
    end
  end

  // Track the read whose data returns next cycle, tagged with its last marker.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_reg      <= 1'b0;
      pend_last_reg <= 1'b0;
    end else begin
      pend_reg      <= issue;
      pend_last_reg <= issue && (rd_left_reg == ONE_L);
    end
  end

  // FIFO storage: capture returning read data with its last tag.
  always_ff @(posedge clk) begin
    if (pend_reg) fifo_mem[wr_ptr_reg] <= {pend_last_reg, dst_d};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      cnt_reg    <= 2'd0;
    end else begin
      if (pend_reg) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)      rd_ptr_reg <= ~rd_ptr_reg;
      cnt_reg <= cnt_reg + {1'b0, pend_reg} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_tiny_dnn_buf_dma.sv
// tb_tiny_dnn_buf_dma: randomized stimulus against a transaction-level reference model.
// Honours TINY_DNN_DMA_LAST_CHECK_EN when expecting src_err.
module tb_tiny_dnn_buf_dma;
  localparam int AW = 12;
  localparam int SW = 16;
  localparam int DW = 32;
  localparam int NW = 4096;
`ifdef TINY_DNN_DMA_LAST_CHECK_EN
  localparam bit EXP_ERR = 1'b1;
`else
  localparam bit EXP_ERR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          src_start = 1'b0;
  logic [AW-1:0] src_base = '0;
  logic [AW:0]   src_len = '0;
  logic          src_busy, src_done;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [SW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          src_v;
  logic [AW-1:0] src_a;
  logic [SW-1:0] src_d;
  logic          dst_start = 1'b0;
  logic [AW-1:0] dst_base = '0;
  logic [AW:0]   dst_len = '0;
  logic          dst_busy, dst_done, dst_v;
  logic [AW-1:0] dst_a;
  logic [DW-1:0] dst_d = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          src_err;

  tiny_dnn_buf_dma #(.AW(AW), .SW(SW), .DW(DW)) dut (
    .clk(clk), .reset(rst),
    .src_start(src_start), .src_base(src_base), .src_len(src_len),
    .src_busy(src_busy), .src_done(src_done),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .src_v(src_v), .src_a(src_a), .src_d(src_d),
    .dst_start(dst_start), .dst_base(dst_base), .dst_len(dst_len),
    .dst_busy(dst_busy), .dst_done(dst_done),
    .dst_v(dst_v), .dst_a(dst_a), .dst_d(dst_d),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .src_err(src_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  // Reference model state (expectations for the current cycle).
  bit          ld_active = 0, ld_exp_v = 0, ld_exp_done = 0, err_model = 0;
  int          ld_left = 0, ld_addr = 0, ld_beats = 0, ld_exp_a = 0, last_idx = 0;
  logic [15:0] ld_exp_d = '0;
  int          src_done_cnt = 0, dst_done_cnt = 0;
  bit          dr_active = 0, dr_exp_done = 0;
  int          dr_base = 0, dr_len = 0, dr_issued = 0, dr_acc = 0;
  int          dr_start_cyc = 0, first_dv_cyc = -1, first_mv_cyc = -1, last_beat_cyc = 0;
  logic [31:0] dst_salt = '0;
  bit          rsp_v = 0;
  logic [AW-1:0] rsp_a = '0;
  int          sv_mode = 0, mr_mode = 0;
  bit          seq_data = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] word(int a);
    return dst_salt ^ (32'h1000_0000 + 32'(a % NW));
  endfunction

  // Input drivers: stream sources/sinks and the destination-buffer read responder.
  always @(negedge clk) begin
    case (sv_mode)
      0:       s_valid = 1'b1;
      1:       s_valid = 1'($urandom_range(0, 1));
      default: s_valid = 1'b0;
    endcase
    s_data = seq_data ? (16'hA001 + 16'(ld_beats)) : 16'($urandom);
    s_last = (ld_beats == last_idx);
    case (mr_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ((cyc % 3) == 0);
      2:       m_ready = 1'($urandom_range(0, 1));
      default: m_ready = 1'b0;
    endcase
    dst_d = rsp_v ? word(int'(rsp_a)) : $urandom;
  end

  // Monitor: compare this cycle against the model, then advance the model.
  always @(negedge clk) begin
    bit ld_was, dr_was;
    #1;
    cyc++;
    if (mon_en) begin
      chk("src_busy", src_busy, ld_active);
      chk("s_ready", s_ready, ld_active);
      chk("src_v", src_v, ld_exp_v);
      if (ld_exp_v) begin
        chk("src_a", src_a, ld_exp_a);
        chk("src_d", src_d, ld_exp_d);
      end
      chk("src_done", src_done, ld_exp_done);
      chk("src_err", src_err, err_model);
      chk("dst_busy", dst_busy, dr_active);
      chk("dst_done", dst_done, dr_exp_done);
      if (!dr_active) chk("m_valid_idle", m_valid, 0);
      if (rst) chk("dst_v_in_reset", dst_v, 0);
      else begin
        if (dst_v) begin
          chk("dst_v_legal", (dr_active && dr_issued < dr_len), 1);
          chk("dst_a", dst_a, (dr_base + dr_issued) % NW);
          if (first_dv_cyc < 0) first_dv_cyc = cyc;
          dr_issued++;
        end
        if (m_valid && dr_active && first_mv_cyc < 0) first_mv_cyc = cyc;
        if (m_valid && m_ready && dr_active) begin
          chk("m_data", m_data, word(dr_base + dr_acc));
          chk("m_last", m_last, (dr_acc == dr_len - 1));
          dr_acc++;
          last_beat_cyc = cyc;
        end
        if (dst_v) chk("occupancy_le2", ((dr_issued - dr_acc) <= 2), 1);
      end
      if (src_done === 1'b1) src_done_cnt++;
      if (dst_done === 1'b1) dst_done_cnt++;
    end
    rsp_v = dst_v && !rst;
    rsp_a = dst_a;
    ld_was = ld_active;
    dr_was = dr_active;
    ld_exp_v = 0;
    ld_exp_done = 0;
    dr_exp_done = 0;
    if (rst) begin
      ld_active = 0;
      dr_active = 0;
      err_model = 0;
    end else begin
      if (ld_was && s_valid) begin
        ld_exp_v = 1;
        ld_exp_a = ld_addr;
        ld_exp_d = s_data;
`ifdef TINY_DNN_DMA_LAST_CHECK_EN
        if (s_last != (ld_left == 1)) err_model = 1;
`endif
        ld_addr = (ld_addr + 1) % NW;
        ld_left--;
        ld_beats++;
        if (ld_left == 0) begin
          ld_active = 0;
          ld_exp_done = 1;
        end
      end else if (!ld_was && src_start) begin
        err_model = 0;
        ld_beats = 0;
        if (src_len == 0) ld_exp_done = 1;
        else begin
          ld_active = 1;
          ld_left = int'(src_len);
          ld_addr = int'(src_base);
        end
      end
      if (dr_was && dr_acc == dr_len) begin
        dr_active = 0;
        dr_exp_done = 1;
      end else if (!dr_was && dst_start) begin
        if (dst_len == 0) dr_exp_done = 1;
        else begin
          dr_active = 1;
          dr_base = int'(dst_base);
          dr_len = int'(dst_len);
          dr_issued = 0;
          dr_acc = 0;
          dr_start_cyc = cyc;
          first_dv_cyc = -1;
          first_mv_cyc = -1;
        end
      end
    end
  end

  task automatic start(bit l, bit d, int lb, int ll, int db, int dl);
    @(negedge clk);
    src_start = l;
    src_base  = AW'(lb);
    src_len   = 13'(ll);
    dst_start = d;
    dst_base  = AW'(db);
    dst_len   = 13'(dl);
    @(negedge clk);
    src_start = 1'b0;
    dst_start = 1'b0;
  endtask

  task automatic wait_idle(string tag, int bound);
    bit ok;
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk);
      #2;
      if (!ld_active && !ld_exp_v && !ld_exp_done && !dr_active && !dr_exp_done) begin
        ok = 1;
        break;
      end
    end
    chk({tag, "_timeout"}, ok, 1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, b, l;
    bit ok;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    #2;
    chk("rst_src_busy", src_busy, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_src_v", src_v, 0);
    chk("rst_dst_busy", dst_busy, 0);
    chk("rst_dst_v", dst_v, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_src_err", src_err, 0);

    // Plan load: base 0x010, len 4, sequential data.
    seq_data = 1; sv_mode = 0; last_idx = 3;
    d0 = src_done_cnt;
    start(1, 0, 'h010, 4, 0, 0);
    wait_idle("load010", 100);
    chk("load010_done_cnt", src_done_cnt - d0, 1);
    $display("load base=010 len=4 beats=%0d", ld_beats);
    seq_data = 0;

    // Address wrap.
    sv_mode = 1;
    start(1, 0, 'hFFE, 4, 0, 0);
    wait_idle("loadFFE", 200);
    $display("load base=ffe len=4 beats=%0d", ld_beats);

    // Zero-length load.
    d0 = src_done_cnt;
    start(1, 0, 'h123, 0, 0, 0);
    wait_idle("load0", 20);
    chk("load0_done_cnt", src_done_cnt - d0, 1);
    $display("load base=123 len=0");

    // Random loads.
    for (int k = 0; k < 6; k++) begin
      b = $urandom_range(0, NW - 1);
      l = $urandom_range(1, 24);
      sv_mode = $urandom_range(0, 1);
      last_idx = l - 1;
      start(1, 0, b, l, 0, 0);
      wait_idle("load_rand", 400);
      chk("load_rand_beats", ld_beats, l);
      $display("load base=%03h len=%0d beats=%0d", b, l, ld_beats);
    end

    // Plan drain: base 0x100, len 3, m_ready held high.
    mr_mode = 0; dst_salt = 32'h0;
    d0 = dst_done_cnt;
    start(0, 1, 0, 0, 'h100, 3);
    wait_idle("drain100", 100);
    chk("drain100_first_dv", first_dv_cyc - dr_start_cyc, 1);
    chk("drain100_first_mv", first_mv_cyc - dr_start_cyc, 3);
    chk("drain100_last_beat", last_beat_cyc - dr_start_cyc, 5);
    chk("drain100_done_cnt", dst_done_cnt - d0, 1);
    $display("drain base=100 len=3 beats=%0d", dr_acc);

    // Drain with m_ready pattern 1,0,0,...
    mr_mode = 1; dst_salt = $urandom;
    b = $urandom_range(0, NW - 1);
    start(0, 1, 0, 0, b, 8);
    wait_idle("drain8", 200);
    chk("drain8_beats", dr_acc, 8);
    $display("drain base=%03h len=8 beats=%0d", b, dr_acc);

    // Zero-length drain.
    d0 = dst_done_cnt;
    start(0, 1, 0, 0, 'h010, 0);
    wait_idle("drain0", 20);
    chk("drain0_done_cnt", dst_done_cnt - d0, 1);
    $display("drain base=010 len=0");

    // Sustained throughput across the address wrap.
    mr_mode = 0; dst_salt = $urandom;
    start(0, 1, 0, 0, 'hFF8, 16);
    wait_idle("drain16", 200);
    chk("drain16_throughput", last_beat_cyc - first_mv_cyc, 15);
    $display("drain base=ff8 len=16 beats=%0d", dr_acc);

    // Concurrent channels, with extra start pulses during activity.
    for (int k = 0; k < 6; k++) begin
      mr_mode = 2; sv_mode = 1; dst_salt = $urandom;
      l = $urandom_range(1, 20);
      last_idx = l - 1;
      start(1, 1, $urandom_range(0, NW - 1), l, $urandom_range(0, NW - 1), $urandom_range(1, 20));
      repeat (2) @(negedge clk);
      start(1, 1, $urandom_range(0, NW - 1), l, $urandom_range(0, NW - 1), $urandom_range(1, 20));
      wait_idle("concurrent", 2000);
      $display("concurrent load_beats=%0d drain_beats=%0d", ld_beats, dr_acc);
    end

    // Reset mid-load after 2 of 5 beats.
    sv_mode = 0; last_idx = 4;
    d0 = src_done_cnt;
    start(1, 0, 'h200, 5, 0, 0);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      if (ld_beats >= 2) begin ok = 1; break; end
    end
    chk("rst_load_progress", ok, 1);
    pulse_reset();
    repeat (8) @(negedge clk);
    chk("rst_load_no_done", src_done_cnt - d0, 0);
    $display("load base=200 len=5 aborted after beats=%0d", ld_beats);

    // Reset mid-drain with the sink stalled.
    mr_mode = 3; dst_salt = $urandom;
    start(0, 1, 0, 0, 'h300, 10);
    repeat (10) @(negedge clk);
    chk("stall_reads_issued", dr_issued, 2);
    d0 = dst_done_cnt;
    pulse_reset();
    mr_mode = 0;
    repeat (8) @(negedge clk);
    chk("rst_drain_no_done", dst_done_cnt - d0, 0);
    $display("drain base=300 len=10 aborted after reads=%0d", dr_issued);

    // Last-marker mismatch: s_last on beat 2 of 3.
    sv_mode = 0; last_idx = 1;
    start(1, 0, 'h040, 3, 0, 0);
    wait_idle("lastchk", 50);
    chk("lastchk_beats", ld_beats, 3);
    chk("lastchk_err", src_err, EXP_ERR);
    last_idx = 1;
    start(1, 0, 'h050, 2, 0, 0);
    wait_idle("lastok", 50);
    chk("lastok_err", src_err, 0);
    $display("load base=040 len=3 bad last, src_err=%0b", src_err);

    // Full-length transfers on both channels together.
    sv_mode = 0; mr_mode = 0; last_idx = NW - 1; dst_salt = $urandom;
    start(1, 1, 'h7A5, NW, 'h3C1, NW);
    wait_idle("full", 5000);
    chk("full_load_beats", ld_beats, NW);
    chk("full_drain_beats", dr_acc, NW);
    $display("full load_beats=%0d drain_beats=%0d", ld_beats, dr_acc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tiny_dnn_buf_dma.md
Name: tiny_dnn_buf_dma

Overview:
- Host-side streaming engine for the core's source and destination buffers.
- Load channel: converts an inbound 16-bit valid/ready stream into sequential source-buffer writes (src_v/src_a/src_d).
- Drain channel: issues sequential destination-buffer reads (dst_v/dst_a), absorbs the buffer's fixed 1-cycle read latency, and emits an outbound 32-bit valid/ready stream with last marking.
- The two channels are independent and may run concurrently.

Parameters:
- AW, 12, buffer address width; buffers hold 2**AW words.
- SW, 16, source word width.
- DW, 32, destination word width.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- src_start  in  1  pulse: begin load using src_base/src_len.
- src_base  in  AW  first source-buffer address.
- src_len  in  AW+1  words to load, 0..4096.
- src_busy  out  1  load channel active.
- src_done  out  1  1-cycle pulse when load completes.
- s_valid  in  1  inbound stream valid.
- s_ready  out  1  inbound stream ready.
- s_data  in  SW  inbound word.
- s_last  in  1  inbound last marker (used only by the optional feature).
- src_v  out  1  source-buffer write strobe.
- src_a  out  AW  source-buffer write address.
- src_d  out  SW  source-buffer write data.
- dst_start  in  1  pulse: begin drain using dst_base/dst_len.
- dst_base  in  AW  first destination-buffer address.
- dst_len  in  AW+1  words to drain, 0..4096.
- dst_busy  out  1  drain channel active.
- dst_done  out  1  1-cycle pulse after the last outbound beat is accepted.
- dst_v  out  1  destination-buffer read strobe.
- dst_a  out  AW  destination-buffer read address.
- dst_d  in  DW  read data, valid the cycle after dst_v.
- m_valid  out  1  outbound stream valid.
- m_ready  in  1  outbound stream ready.
- m_data  out  DW  outbound word.
- m_last  out  1  high on the final outbound beat.
- src_err  out  1  sticky last-mismatch flag (optional feature only; otherwise tied 0).

Behaviour:
- Reset: all outputs 0; both channels IDLE; output FIFO emptied.
- Reset asserted mid-transfer aborts the transfer immediately. No done pulse is generated and no further src_v/dst_v is issued.
- Load FSM IDLE -> LOAD -> IDLE:
  - src_start in IDLE latches base and len. Next cycle: src_busy=1, s_ready=1.
  - len=0 gives no LOAD state; src_done pulses the cycle after start and busy stays 0.
  - In LOAD, each s_valid&&s_ready handshake produces registered src_v=1, src_a=addr, src_d=s_data on the next cycle.
  - addr increments modulo 2**AW, so it wraps 4095 -> 0.
  - After the len-th handshake: s_ready drops that same edge, busy clears, and src_done pulses coincident with the final src_v.
- Drain FSM IDLE -> READ -> FLUSH -> IDLE:
  - The output FIFO is 2 entries.
  - Read issue rule: dst_v asserts when reads_remaining>0 and (fifo_count + inflight) < 2.
  - The word read arrives on dst_d the following cycle and is written into the FIFO at the end of that cycle.
  - m_valid = FIFO not empty; m_data/m_last come from the FIFO head.
  - m_last is tagged onto the len-th word.
  - Timing from dst_start at edge T (m_ready held 1): dst_v in cycle T+1, dst_d in T+2, m_valid in T+3. Sustained throughput is 1 word/cycle.
  - With m_ready=0 and the FIFO full, dst_v stays 0; no data loss and no reordering.
  - FLUSH waits for the FIFO to empty. dst_done pulses the cycle after the m_last handshake.
  - len=0: dst_done pulses the cycle after start; no dst_v is issued.
- dst_a increments modulo 2**AW.
- Start pulses received while the corresponding channel is busy are ignored.
- Simultaneous src_start and dst_start are both accepted.
- Input handshakes outside LOAD are not accepted (s_ready=0).

Optional Feature:
- Macro: TINY_DNN_DMA_LAST_CHECK_EN.
- Defined:
  - src_err sets if s_last=1 on any accepted beat other than the len-th, or s_last=0 on the len-th.
  - src_err is sticky until reset or the next src_start.
  - The load still completes after exactly len beats.
- Undefined: s_last is ignored and src_err is held 0.

Test Plan:
- Load base=0x010, len=4, s_valid always 1, data 0xA001..0xA004 -> src_v on 4 consecutive cycles at addresses 0x010..0x013 with matching data; src_done coincides with the 4th src_v.
- Load base=0xFFE, len=4 -> addresses 0xFFE, 0xFFF, 0x000, 0x001.
- Drain base=0x100, len=3, dst model returns 0x1000_0000+addr one cycle after dst_v, m_ready=1 -> m_data 0x1000_0100/0101/0102 starting at T+3; m_last on the 3rd beat; dst_done one cycle later.
- Drain len=8 with m_ready toggling 1,0,0,1,... -> all 8 words delivered in order; never more than 2 words outstanding or buffered.
- Reset asserted after 2 of 5 load beats -> src_v, src_busy and s_ready go 0 the next cycle; no src_done.
- With TINY_DNN_DMA_LAST_CHECK_EN defined: len=3 with s_last on beat 2 -> src_err=1 and load completes after beat 3. Without the macro: src_err stays 0.
